seq_shift_add_mult: RTL and testbench
=====================================

// Module: seq_shift_add_mult
// PURPOSE
//   Sequential shift-add unsigned multiplier controller: sequences one shared
//   WIDTH-bit adder over WIDTH cycles to form a 2*WIDTH-bit product.
//   Trades latency for area against the array multiplier; sits between a
//   start/done requester and the bit-level adder cells of the multiplier library.
// PARAMETERS
//   WIDTH   8   operand width in bits (>=2); product is 2*WIDTH bits
// PORTS
//   clk      in   1         single clock, rising edge
//   rst      in   1         synchronous, active-high reset
//   start    in   1         request; sampled only in IDLE or DONE
//   A        in   WIDTH     multiplicand, captured on accepted start
//   B        in   WIDTH     multiplier, captured on accepted start
//   busy     out  1         high while in BUSY state
//   done     out  1         one-cycle pulse: Product is valid
//   Product  out  2*WIDTH   result; held stable until next accepted start
// BEHAVIOUR
//   - Reset (rst=1 at clk edge): state=IDLE, busy=0, done=0, Product=0,
//     internal regs and counter=0. Reset wins over every other event,
//     including mid-operation: the computation in flight is abandoned.
//   - FSM: IDLE -start-> BUSY; BUSY -(cnt==WIDTH-1)-> DONE;
//     DONE -start-> BUSY, DONE -!start-> IDLE. busy and done are registered
//     (busy=1 iff state==BUSY, done=1 iff state==DONE).
//   - Accept: edge k with start=1 in IDLE/DONE latches mcand<=A,
//     mplier<=B, acc<=0, cnt<=0. start in BUSY is ignored (no re-latch).
//   - Iteration (each BUSY cycle): sum[WIDTH:0] = acc + (mplier[0] ? mcand : 0)
//     via the adder sub-module (carry-out kept as bit WIDTH);
//     {acc, mplier} <= {sum, mplier[WIDTH-1:1]} (shift right 1 of the
//     (2*WIDTH+1)-bit concatenation); cnt <= cnt+1.
//   - Latency: accept at edge k -> BUSY for edges k+1..k+WIDTH -> at edge
//     k+WIDTH Product<={acc,mplier} final value and state=DONE, so done=1 in
//     cycle after edge k+WIDTH; WIDTH+1 cycles start-to-done.
//   - Product changes only at the transition into DONE (or reset); it does not
//     glitch during BUSY. Back-to-back: start high in DONE cycle starts the next
//     op with no IDLE cycle; throughput one result per WIDTH+1 cycles.
//   - Arithmetic: unsigned; no overflow possible (2*WIDTH-bit result exact).
//     cnt width = $clog2(WIDTH)+1; counter never wraps inside one operation.
//   - A/B may change freely after acceptance; only latched copies are used.
// STRUCTURE
//   - Include file mult_defs.vh: state encodings (ST_IDLE=2'd0, ST_BUSY=2'd1,
//     ST_DONE=2'd2; 2'd3 illegal -> next state IDLE) shared with other
//     multiplier controllers.
//   - One sub-module: ripple_adder_n #(WIDTH) — WIDTH-bit ripple-carry adder
//     (cin=0) built from the existing half_adder (bit 0) and full-adder cells;
//     outputs sum[WIDTH-1:0] and cout. FSM, counter and shift register remain in
//     this module.
// TESTING
//   - Reset: rst=1 for 2 cycles -> busy=0, done=0, Product=16'h0000.
//   - WIDTH=8, A=8'h0F, B=8'h0F, start 1 cycle -> done pulses exactly 9 cycles
//     after the accept edge, Product=16'h00E1, busy high exactly 8 cycles.
//   - A=8'hFF, B=8'hFF -> Product=16'hFE01 (carry-out path exercised);
//     A=8'h00, B=8'hA5 -> 16'h0000; A=8'h01, B=8'h80 -> 16'h0080.
//   - start held high with new A=3,B=5 during BUSY of 7*6 -> Product=16'd42,
//     then start held in DONE cycle -> next op accepted, done +9 cycles,
//     Product=16'd15.
//   - rst asserted at 4th BUSY cycle -> next cycle IDLE, busy=0, done never
//     pulses, Product=0; a fresh start then completes normally.
//   - 1000 random A/B with random start gaps vs. reference model A*B, also run
//     at WIDTH=4 and WIDTH=16.

Source files
------------

// File: rtl/seq_shift_add_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier controller.
// State encodings match the other multiplier controllers; 2'd3 is illegal.
package seq_shift_add_mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Iteration counter width for a given operand width.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/seq_shift_add_mult_adder.sv
// WIDTH-bit ripple-carry adder (carry-in tied low) built from half/full adder
// cells; the low bit uses a half adder since there is no carry into it.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module ripple_adder_n #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH:1] carry;

    half_adder u_ha0 (
        .a (a[0]),
        .b (b[0]),
        .s (sum[0]),
        .c (carry[1])
    );

    for (genvar i = 1; i < WIDTH; i++) begin : g_fa
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (carry[i]),
            .s  (sum[i]),
            .co (carry[i+1])
        );
    end

    assign cout = carry[WIDTH];
endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential unsigned shift-add multiplier: one shared WIDTH-bit adder iterated
// WIDTH times per operation, start/busy/done handshake, product held until next start.
module seq_shift_add_mult
    import seq_shift_add_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] Product
);
    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    state_t             state;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   acc;
    logic [CW-1:0]      cnt;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum_lo;
    logic               cout;
    logic [2*WIDTH-1:0] shifted;

    assign addend = mplier[0] ? mcand : '0;

    ripple_adder_n #(.WIDTH(WIDTH)) u_adder (
        .a    (acc),
        .b    (addend),
        .sum  (sum_lo),
        .cout (cout)
    );

    // {acc, mplier} after one step: the adder result (with carry) shifted right by one.
    assign shifted = {cout, sum_lo, mplier[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            Product <= '0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand  <= A;
                        mplier <= B;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= ST_BUSY;
                        busy   <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    {acc, mplier} <= shifted;
                    cnt           <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        Product <= shifted;
                        state   <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Bench for seq_shift_add_mult at WIDTH 4, 8 and 16: directed cases plus
// randomized operations compared against plain A*B.
module tb_seq_shift_add_mult;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  start_w;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic [2:0]  busy_w;
    logic [2:0]  done_w;
    logic [7:0]  prod4;
    logic [15:0] prod8;
    logic [31:0] prod16;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] last_prod [3];

    always #5 clk = ~clk;

    seq_shift_add_mult #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst(rst), .start(start_w[0]), .A(a_in[3:0]), .B(b_in[3:0]),
        .busy(busy_w[0]), .done(done_w[0]), .Product(prod4)
    );
    seq_shift_add_mult #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .start(start_w[1]), .A(a_in[7:0]), .B(b_in[7:0]),
        .busy(busy_w[1]), .done(done_w[1]), .Product(prod8)
    );
    seq_shift_add_mult #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst(rst), .start(start_w[2]), .A(a_in), .B(b_in),
        .busy(busy_w[2]), .done(done_w[2]), .Product(prod16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int width_of(input int sel);
        return (sel == 0) ? 4 : (sel == 1) ? 8 : 16;
    endfunction

    function automatic logic [31:0] prod_of(input int sel);
        case (sel)
            0:       return {24'b0, prod4};
            1:       return {16'b0, prod8};
            default: return prod16;
        endcase
    endfunction

    // Called at a negedge with the chosen instance in IDLE or DONE.
    task automatic do_op(input int sel, input logic [15:0] a, input logic [15:0] b, input int gap);
        int          w;
        int          n;
        int          nbusy;
        logic [31:0] mask;
        logic [31:0] expp;
        w     = width_of(sel);
        mask  = (32'd1 << w) - 32'd1;
        expp  = ({16'b0, a} & mask) * ({16'b0, b} & mask);
        a_in  = a;
        b_in  = b;
        start_w[sel] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_w[sel] = 1'b0;
        a_in  = 16'($urandom);
        b_in  = 16'($urandom);
        n     = 0;
        nbusy = busy_w[sel] ? 1 : 0;
        while (!done_w[sel] && n < w + 4) begin
            check("prod_hold", prod_of(sel), last_prod[sel]);
            @(negedge clk);
            n++;
            if (busy_w[sel]) nbusy++;
        end
        check("latency", 32'(n), 32'(w));
        check("busy_cycles", 32'(nbusy), 32'(w));
        check("product", prod_of(sel), expp);
        last_prod[sel] = expp;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            if (g == 0) check("done_pulse", {31'b0, done_w[sel]}, 32'd0);
        end
    endtask

    initial begin
        int n;
        int seen_done;
        rst     = 1'b1;
        start_w = '0;
        a_in    = '0;
        b_in    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            check("rst_busy", {31'b0, busy_w[s]}, 32'd0);
            check("rst_done", {31'b0, done_w[s]}, 32'd0);
            check("rst_prod", prod_of(s), 32'd0);
            last_prod[s] = '0;
        end
        rst = 1'b0;
        @(negedge clk);

        do_op(1, 16'h000F, 16'h000F, 1);
        do_op(1, 16'h00FF, 16'h00FF, 2);
        do_op(1, 16'h0000, 16'h00A5, 0);
        do_op(1, 16'h0001, 16'h0080, 1);

        // Start held high across BUSY with new operands, then held into DONE.
        a_in = 16'd7;
        b_in = 16'd6;
        start_w[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_in = 16'd3;
        b_in = 16'd5;
        n = 0;
        while (!done_w[1] && n < 12) begin
            @(negedge clk);
            n++;
        end
        check("held_latency1", 32'(n), 32'd8);
        check("held_prod1", prod_of(1), 32'd42);
        @(posedge clk);
        @(negedge clk);
        start_w[1] = 1'b0;
        check("held_busy2", {31'b0, busy_w[1]}, 32'd1);
        n = 0;
        while (!done_w[1] && n < 12) begin
            @(negedge clk);
            n++;
        end
        check("held_latency2", 32'(n), 32'd8);
        check("held_prod2", prod_of(1), 32'd15);
        last_prod[1] = 32'd15;
        @(negedge clk);

        // Reset in the 4th BUSY cycle abandons the operation.
        a_in = 16'd9;
        b_in = 16'd9;
        start_w[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_w[1] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", {31'b0, busy_w[1]}, 32'd0);
        check("midrst_done", {31'b0, done_w[1]}, 32'd0);
        check("midrst_prod", prod_of(1), 32'd0);
        seen_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done_w[1]) seen_done++;
        end
        check("midrst_no_done", 32'(seen_done), 32'd0);
        for (int s = 0; s < 3; s++) last_prod[s] = '0;
        do_op(1, 16'h002D, 16'h0013, 1);

        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 1000; i++) begin
                do_op(s, 16'($urandom), 16'($urandom), int'($urandom_range(0, 3)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
